piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter; the driving end for a shift-register or D-flip-flop receive chain that samples one bit per enabled clock.
- Accepts WIDTH-bit words over a valid/ready handshake and holds one word in a holding buffer.
- Shifts each word out one bit per `shift_en` tick, with true and complementary serial outputs and frame markers.
- Sits between a word-level producer and a bit-serial link.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- shift_en  input  1  bit-rate tick; serial state advances only on edges where it is 1.
- load_valid  input  1  producer has a word on `load_data`.
- load_data  input  WIDTH  word to transmit.
- load_ready  output  1  holding buffer is empty; equals the inverse of the `hold_full` register.
- sdo  output  1  serial data, registered.
- sdo_n  output  1  registered complement of `sdo`; always equal to the inverse of `sdo`.
- sdo_valid  output  1  the current `sdo` bit belongs to a frame.
- frame_start  output  1  the current bit is the first bit of a word.
- frame_last  output  1  the current bit is the last bit of a word.
- busy  output  1  `sdo_valid` OR `hold_full`.

Behaviour:
- Reset, one edge with `rst` = 1:
  - sdo=0, sdo_n=1, sdo_valid=0, frame_start=0, frame_last=0.
  - hold_full=0, so load_ready=1 and busy=0.
  - bits_left=0; shift register cleared.
  - `rst` has priority over every other input.
- Reset mid-frame aborts the word in flight and discards any held word; no partial bits are emitted after reset.
- Handshake:
  - A word is accepted on an edge where `load_valid` && `load_ready`; it is captured into the hold register and hold_full goes to 1.
  - There is no same-cycle bypass; `load_ready` depends only on registered state.
  - `load_data` is ignored when not accepted.
  - The handshake is independent of `shift_en`.
- Internal state:
  - shift register, WIDTH bits.
  - bits_left counter, width $clog2(WIDTH+1).
  - hold register plus hold_full flag.
- Two states, derived from the counter and output flags:
  - IDLE: bits_left=0 and sdo_valid=0.
  - SHIFT: a frame is in progress.
- On an edge with shift_en=1 and rst=0, the first matching case below applies.
  - bits_left > 0:
    - Present the next bit on `sdo` and its inverse on `sdo_n`.
    - Shift the register; bits_left decrements.
    - sdo_valid=1, frame_start=0.
    - frame_last=1 iff bits_left was 1.
  - bits_left = 0 and hold_full = 1:
    - Move the hold register into the shift register and clear hold_full.
    - Present the first bit: sdo_valid=1, frame_start=1, frame_last=0.
    - bits_left = WIDTH-1.
  - Otherwise (IDLE):
    - sdo_valid=0, frame_start=0, frame_last=0.
    - sdo and sdo_n keep their previous values.
- On an edge with shift_en=0: all serial outputs and bits_left hold. The handshake still operates.
- Accept and consume of the hold register can never occur on the same edge: accept requires hold_full=0, consume requires hold_full=1.
- Latency: a word accepted at edge N has its first bit on `sdo` after the first shift_en edge strictly later than N (edge N+1 at the earliest).
- Throughput: with shift_en tied high and the producer always valid, frames are gapless.
  - WIDTH bits per word; frame_last of word k is followed directly by frame_start of word k+1.
  - The next word is accepted while the current one is shifting.
- Bit order per MSB_FIRST. The shift register shifts left for MSB-first and right for LSB-first; vacated bits fill with 0.
- The transmitter has no flow control toward the link; the receiver samples `sdo` on edges after each shift_en tick.

Test Plan:
- Reset: assert rst for 2 cycles with load_valid=1 and shift_en=1 -> sdo=0, sdo_n=1, sdo_valid=0, load_ready=1, busy=0; no word accepted.
- Single word, MSB_FIRST=1, WIDTH=8, load 8'hA5, shift_en=1 -> next 8 edges give sdo=1,0,1,0,0,1,0,1.
  - sdo_n is the inverse on every cycle.
  - frame_start only on the first bit, frame_last only on the eighth.
  - Then sdo_valid=0 and busy=0.
- Back-to-back: loads 8'h0F then 8'hF0, load_valid held high, shift_en=1 -> 16 contiguous valid bits 0000111111110000.
  - load_ready drops to 0 while the second word is held.
  - frame_start on bits 1 and 9.
- Gated rate: shift_en pulsed every 4th cycle, load 8'h81 -> each bit is held 4 cycles; the frame completes after 8 ticks; outputs are frozen between ticks.
- Reset mid-frame: load 8'hFF, shift 3 bits, hold a queued 8'h00, pulse rst -> all outputs at reset values; no further valid bits after reset is released.
- LSB_FIRST (MSB_FIRST=0), load 8'h01 -> first bit sdo=1 with frame_start=1, then seven 0s with frame_last on the eighth.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer and
// frame markers; serial state advances only on shift_en ticks.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_n,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    bits_left_q, bits_left_d;
  logic             sdo_q, sdo_d;
  logic             sdo_n_q, sdo_n_d;
  logic             sdo_valid_q, sdo_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_last_q, frame_last_d;

  logic             accept;
  logic             do_shift;
  logic             do_load;
  logic [WIDTH-1:0] src_word;
  logic             src_bit;
  logic [WIDTH-1:0] src_shifted;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    bits_left_d   = bits_left_q;
    sdo_d         = sdo_q;
    sdo_n_d       = sdo_n_q;
    sdo_valid_d   = sdo_valid_q;
    frame_start_d = frame_start_q;
    frame_last_d  = frame_last_q;

    accept   = load_valid && !hold_full_q;
    do_shift = shift_en && (state_q == SHIFT) && (bits_left_q != '0);
    do_load  = shift_en && !do_shift && hold_full_q;

    // Loading and shifting share one bit-select/shift path; the source word
    // is the hold register on a load, the shift register otherwise.
    src_word = do_load ? hold_q : shift_q;
    if (MSB_FIRST) begin
      src_bit     = src_word[WIDTH-1];
      src_shifted = src_word << 1;
    end else begin
      src_bit     = src_word[0];
      src_shifted = src_word >> 1;
    end

    if (accept) begin
      hold_d      = load_data;
      hold_full_d = 1'b1;
    end

    if (do_shift || do_load) begin
      sdo_d         = src_bit;
      sdo_n_d       = ~src_bit;
      shift_d       = src_shifted;
      sdo_valid_d   = 1'b1;
      frame_start_d = do_load;
      frame_last_d  = do_shift && (bits_left_q == CW'(1));
      bits_left_d   = do_load ? CW'(WIDTH - 1) : bits_left_q - CW'(1);
      if (do_load) begin
        hold_full_d = 1'b0;
      end
    end else if (shift_en) begin
      sdo_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      frame_last_d  = 1'b0;
    end

    state_d = ((bits_left_d != '0) || sdo_valid_d) ? SHIFT : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      bits_left_q   <= '0;
      sdo_q         <= 1'b0;
      sdo_n_q       <= 1'b1;
      sdo_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      bits_left_q   <= bits_left_d;
      sdo_q         <= sdo_d;
      sdo_n_q       <= sdo_n_d;
      sdo_valid_q   <= sdo_valid_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
    end
  end

  assign load_ready  = ~hold_full_q;
  assign sdo         = sdo_q;
  assign sdo_n       = sdo_n_q;
  assign sdo_valid   = sdo_valid_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
  assign busy        = sdo_valid_q | hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: vector table for reset, single and
// back-to-back frames, then gated-rate, mid-frame reset and LSB-first runs.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst, shift_en, load_valid;
  logic [7:0] load_data;
  logic       load_ready, sdo, sdo_n, sdo_valid, frame_start, frame_last, busy;

  logic       load_valid2;
  logic [7:0] load_data2;
  logic       load_ready2, sdo2, sdo_n2, sdo_valid2, frame_start2, frame_last2, busy2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .shift_en(shift_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .sdo(sdo), .sdo_n(sdo_n), .sdo_valid(sdo_valid),
    .frame_start(frame_start), .frame_last(frame_last), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .shift_en(shift_en),
    .load_valid(load_valid2), .load_data(load_data2), .load_ready(load_ready2),
    .sdo(sdo2), .sdo_n(sdo_n2), .sdo_valid(sdo_valid2),
    .frame_start(frame_start2), .frame_last(frame_last2), .busy(busy2)
  );

  typedef struct {
    logic       rst, se, lv;
    logic [7:0] d;
    logic       sdo, vld, fs, fl, rdy, bsy;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(logic r, logic s, logic l, logic [7:0] d,
                              logic o, logic v, logic fs, logic fl,
                              logic rdy, logic bsy);
    vec_t x;
    x.rst = r; x.se = s; x.lv = l; x.d = d;
    x.sdo = o; x.vld = v; x.fs = fs; x.fl = fl; x.rdy = rdy; x.bsy = bsy;
    return x;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic l, input logic [7:0] d);
    rst = r; shift_en = s; load_valid = l; load_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_msb(input string tag, input logic o, input logic v, input logic fs,
                         input logic fl, input logic rdy, input logic bsy);
    chk({tag, "_sdo"}, sdo, o);
    chk({tag, "_sdo_n"}, sdo_n, ~o);
    chk({tag, "_valid"}, sdo_valid, v);
    chk({tag, "_fstart"}, frame_start, fs);
    chk({tag, "_flast"}, frame_last, fl);
    chk({tag, "_ready"}, load_ready, rdy);
    chk({tag, "_busy"}, busy, bsy);
  endtask

  initial begin
    logic [7:0] w;
    logic       b;

    rst = 1'b1; shift_en = 1'b0; load_valid = 1'b0; load_data = '0;
    load_valid2 = 1'b0; load_data2 = '0;

    // reset, single 8'hA5, back-to-back 8'h0F / 8'hF0
    vecs[0]  = mk(1, 1, 1, 8'hAA, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 1, 1, 8'hAA, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 1, 8'hA5, 0, 0, 0, 0, 0, 1);
    vecs[3]  = mk(0, 1, 0, 8'h00, 1, 1, 1, 0, 1, 1);
    vecs[4]  = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1);
    vecs[5]  = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 1, 1);
    vecs[6]  = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1);
    vecs[7]  = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1);
    vecs[8]  = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 1, 1);
    vecs[9]  = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1);
    vecs[10] = mk(0, 1, 0, 8'h00, 1, 1, 0, 1, 1, 1);
    vecs[11] = mk(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    vecs[12] = mk(0, 1, 1, 8'h0F, 1, 0, 0, 0, 0, 1);
    vecs[13] = mk(0, 1, 1, 8'hF0, 0, 1, 1, 0, 1, 1);
    vecs[14] = mk(0, 1, 1, 8'hF0, 0, 1, 0, 0, 0, 1);
    vecs[15] = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 1);
    vecs[16] = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 1);
    vecs[17] = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 1);
    vecs[18] = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 1);
    vecs[19] = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 1);
    vecs[20] = mk(0, 1, 0, 8'h00, 1, 1, 0, 1, 0, 1);
    vecs[21] = mk(0, 1, 0, 8'h00, 1, 1, 1, 0, 1, 1);
    vecs[22] = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 1, 1);
    vecs[23] = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 1, 1);
    vecs[24] = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 1, 1);
    vecs[25] = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1);
    vecs[26] = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1);
    vecs[27] = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1);
    vecs[28] = mk(0, 1, 0, 8'h00, 0, 1, 0, 1, 1, 1);
    vecs[29] = mk(0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 30; i++) begin
      step(vecs[i].rst, vecs[i].se, vecs[i].lv, vecs[i].d);
      chk_msb($sformatf("v%0d", i), vecs[i].sdo, vecs[i].vld, vecs[i].fs,
              vecs[i].fl, vecs[i].rdy, vecs[i].bsy);
    end

    // gated rate: one tick every 4 cycles, outputs frozen in between
    w = 8'h81;
    step(0, 0, 1, w);
    chk_msb("gate_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      b = w[7 - k];
      step(0, 1, 0, 8'h00);
      chk_msb($sformatf("gate_t%0d", k), b, 1'b1, k == 0, k == 7, 1'b1, 1'b1);
      for (int h = 0; h < 3; h++) begin
        step(0, 0, 0, 8'h00);
        chk_msb($sformatf("gate_t%0d_h%0d", k, h), b, 1'b1, k == 0, k == 7, 1'b1, 1'b1);
      end
    end
    step(0, 1, 0, 8'h00);
    chk_msb("gate_end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-frame with a queued word
    step(0, 0, 1, 8'hFF);
    step(0, 1, 0, 8'h00);
    chk_msb("mid_b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(0, 1, 1, 8'h00);
    chk_msb("mid_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 1, 0, 8'h00);
    chk_msb("mid_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1, 1, 1, 8'h55);
    chk_msb("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, 8'h00);
      chk_msb($sformatf("mid_after%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // LSB-first instance, word 8'h01
    load_valid2 = 1'b1; load_data2 = 8'h01;
    step(0, 0, 0, 8'h00);
    load_valid2 = 1'b0; load_data2 = 8'hFF;
    chk("lsb_ready_after_accept", load_ready2, 1'b0);
    chk("lsb_busy_after_accept", busy2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      b = (k == 0);
      step(0, 1, 0, 8'h00);
      chk($sformatf("lsb_b%0d_sdo", k), sdo2, b);
      chk($sformatf("lsb_b%0d_sdo_n", k), sdo_n2, ~b);
      chk($sformatf("lsb_b%0d_valid", k), sdo_valid2, 1'b1);
      chk($sformatf("lsb_b%0d_fstart", k), frame_start2, k == 0);
      chk($sformatf("lsb_b%0d_flast", k), frame_last2, k == 7);
    end
    step(0, 1, 0, 8'h00);
    chk("lsb_end_valid", sdo_valid2, 1'b0);
    chk("lsb_end_busy", busy2, 1'b0);
    chk("lsb_end_ready", load_ready2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
